// File: rtl/serializador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializador_pkg
// Description : Shared constants for the accumulator serial output stage:
//               FSM state encodings, idle line level and frame length.
//               Frame length honours SERIALIZADOR_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package serializador_pkg;

    // FSM state encoding (3-bit)
    localparam int         c_state_w   = 3;
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_flag   = 3'd3;
    localparam logic [2:0] c_st_parity = 3'd4;
    localparam logic [2:0] c_st_stop   = 3'd5;

    // Level the serial line rests at between frames
    localparam logic c_line_idle = 1'b1;

    // Default accumulator width
    localparam int c_data_w_def = 6;

    // Bits per frame: start + data + flag (+ parity) + stop
    function automatic int frame_bits(input int data_w);
`ifdef SERIALIZADOR_PARITY_EN
        return data_w + 4;
`else
        return data_w + 3;
`endif
    endfunction

    localparam int c_frame_bits = frame_bits(c_data_w_def);

endpackage
`default_nettype wire

// File: rtl/contador_baudios.sv
`default_nettype none
// ============================================================================
// Module      : contador_baudios
// Description : Baud counter. Counts 0..CLKS_PER_BIT-1 while enabled and
//               emits a one-cycle tick on the last count. A synchronous clear
//               restarts the bit period (used on every FSM state change).
// Revision    : 1.0 - initial release
// ============================================================================
module contador_baudios #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int                 c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Tick on the final count of each bit period
    assign o_tick = i_en && (r_cnt == c_cnt_max);

    // Count clock cycles within the current bit, wrapping on the tick
    always_ff @(posedge clock) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : (r_cnt + c_cnt_w'(1));
        end
    end

endmodule
`default_nettype wire

// File: rtl/serializador_acum.sv
`default_nettype none
// ============================================================================
// Module      : serializador_acum
// Description : Serialises the accumulator value and overflow flag as a
//               UART-style frame: start, data LSB first, flag, [parity], stop.
//               Keeps a sticky overflow flag between frame captures.
//               Optional even parity bit: define SERIALIZADOR_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serializador_acum
    import serializador_pkg::*;
#(
    parameter int DATA_W       = 6,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clock,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_overflow,
    input  logic              i_start,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ovf_sticky
);

    localparam int                 c_idx_w    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_W - 1);

    logic [c_state_w-1:0] r_state;
    logic [DATA_W-1:0]    r_shift;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic                 r_flag;
    logic                 r_sticky;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
`ifdef SERIALIZADOR_PARITY_EN
    logic                 r_parity;
`endif

    logic [c_state_w-1:0] w_state_next;
    logic [DATA_W-1:0]    w_shift_next;
    logic                 w_tx_next;
    logic                 w_tick;
    logic                 w_capture;
    logic                 w_flag_cap;
    logic                 w_clr;

    assign w_capture  = (r_state == c_st_idle) && i_start;
    // Sticky plus same-cycle overflow so no event is missed at capture
    assign w_flag_cap = r_sticky | i_overflow;
    // Every state change restarts the bit period
    assign w_clr      = i_rst || (w_state_next != r_state);

    contador_baudios #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_contador_baudios (
        .clock  (clock),
        .i_clr  (w_clr),
        .i_en   (r_state != c_st_idle),
        .o_tick (w_tick)
    );

    // Next-state logic of the frame sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (i_start) w_state_next = c_st_start;
            c_st_start:  if (w_tick)  w_state_next = c_st_data;
            c_st_data:   if (w_tick && (r_bit_idx == c_idx_last)) w_state_next = c_st_flag;
`ifdef SERIALIZADOR_PARITY_EN
            c_st_flag:   if (w_tick)  w_state_next = c_st_parity;
            c_st_parity: if (w_tick)  w_state_next = c_st_stop;
`else
            c_st_flag:   if (w_tick)  w_state_next = c_st_stop;
`endif
            c_st_stop:   if (w_tick)  w_state_next = c_st_idle;
            default:                  w_state_next = c_st_idle;
        endcase
    end

    // Shift register load/shift and the registered line level for next cycle
    always_comb begin
        w_shift_next = r_shift;
        if (w_capture) begin
            w_shift_next = i_data;
        end else if ((r_state == c_st_data) && w_tick) begin
            w_shift_next = r_shift >> 1;
        end

        w_tx_next = c_line_idle;
        case (w_state_next)
            c_st_start:  w_tx_next = ~c_line_idle;
            c_st_data:   w_tx_next = w_shift_next[0];
            c_st_flag:   w_tx_next = r_flag;
`ifdef SERIALIZADOR_PARITY_EN
            c_st_parity: w_tx_next = r_parity;
`endif
            default:     w_tx_next = c_line_idle;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_state   <= c_st_idle;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_flag    <= 1'b0;
            r_sticky  <= 1'b0;
            r_tx      <= c_line_idle;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;

            if (r_state != c_st_data) begin
                r_bit_idx <= '0;
            end else if (w_tick) begin
                r_bit_idx <= (r_bit_idx == c_idx_last) ? '0 : (r_bit_idx + c_idx_w'(1));
            end

            if (w_capture) begin
                r_flag <= w_flag_cap;
`ifdef SERIALIZADOR_PARITY_EN
                r_parity <= (^i_data) ^ w_flag_cap;
`endif
            end

            // Capture clears: an overflow on that edge is already in the frame
            r_sticky <= w_capture ? 1'b0 : (r_sticky | i_overflow);

            r_tx   <= w_tx_next;
            r_busy <= (w_state_next != c_st_idle);
            r_done <= (r_state == c_st_stop) && w_tick;
        end
    end

    assign o_tx         = r_tx;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_ovf_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_serializador_acum.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializador_acum
// Description : Self-checking bench for serializador_acum. Expected line
//               levels come from a frame bit list built from the frame rules;
//               the sticky flag is tracked as "overflow seen since capture".
//               Parity case runs when SERIALIZADOR_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializador_acum;
    import serializador_pkg::*;

    localparam int DATA_W = 6;
    localparam int CPB    = 4;
    localparam int N      = frame_bits(DATA_W);

    logic              clock = 1'b0;
    logic              i_rst = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_overflow = 1'b0;
    logic              i_start = 1'b0;
    logic              o_tx;
    logic              o_busy;
    logic              o_done;
    logic              o_ovf_sticky;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;
    bit m_sticky = 1'b0;

    always #5 clock = ~clock;

    serializador_acum #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock        (clock),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_overflow   (i_overflow),
        .i_start      (i_start),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_ovf_sticky (o_ovf_sticky)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
        if (o_busy) busy_cnt++;
    endtask

    task automatic idle_cycles(input int n, input bit rand_ovf);
        i_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit r;
            r = rand_ovf && ($urandom_range(0, 3) == 0);
            i_overflow = r;
            step();
            m_sticky |= r;
            i_overflow = 1'b0;
            check_val("idle_tx",     32'(o_tx),         32'd1);
            check_val("idle_busy",   32'(o_busy),       32'd0);
            check_val("idle_done",   32'(o_done),       32'd0);
            check_val("idle_sticky", 32'(o_ovf_sticky), 32'(m_sticky));
        end
    endtask

    // Send one frame and check every cycle of it against the expected bit list
    task automatic run_frame(input logic [DATA_W-1:0] d, input bit ovf_cap,
                             input bit rand_ovf, input bit hold_start);
        bit exp_bits[$];
        bit flag;
        flag = m_sticky | ovf_cap;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(flag);
`ifdef SERIALIZADOR_PARITY_EN
        exp_bits.push_back((^d) ^ flag);
`endif
        exp_bits.push_back(1'b1);

        i_data     = d;
        i_overflow = ovf_cap;
        i_start    = 1'b1;
        step();
        m_sticky   = 1'b0;
        i_overflow = 1'b0;
        if (!hold_start) i_start = 1'b0;
        check_val("cap_sticky", 32'(o_ovf_sticky), 32'd0);
        i_data = DATA_W'($urandom);

        for (int j = 0; j < N * CPB; j++) begin
            bit r;
            check_val($sformatf("tx[%0d]", j),   32'(o_tx),   32'(exp_bits[j / CPB]));
            check_val($sformatf("busy[%0d]", j), 32'(o_busy), 32'd1);
            check_val($sformatf("done[%0d]", j), 32'(o_done), 32'd0);
            r = rand_ovf && ($urandom_range(0, 7) == 0);
            i_overflow = r;
            step();
            m_sticky |= r;
            i_overflow = 1'b0;
        end
        check_val("end_done",   32'(o_done),       32'd1);
        check_val("end_busy",   32'(o_busy),       32'd0);
        check_val("end_tx",     32'(o_tx),         32'd1);
        check_val("end_sticky", 32'(o_ovf_sticky), 32'(m_sticky));
    endtask

    initial begin
        int done_seen;

        // Reset held for three cycles
        i_rst = 1'b1;
        repeat (3) step();
        check_val("rst_tx",     32'(o_tx),         32'd1);
        check_val("rst_busy",   32'(o_busy),       32'd0);
        check_val("rst_done",   32'(o_done),       32'd0);
        check_val("rst_sticky", 32'(o_ovf_sticky), 32'd0);
        i_rst = 1'b0;
        idle_cycles(2, 1'b0);

        // Basic frame
        run_frame(6'h2D, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);

        // Sticky overflow captured into the next frame
        i_overflow = 1'b1;
        step();
        i_overflow = 1'b0;
        m_sticky   = 1'b1;
        check_val("sticky_set", 32'(o_ovf_sticky), 32'd1);
        run_frame(6'h00, 1'b0, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);

        // Start held across the frame: ignored while busy, then back-to-back
        busy_cnt = 0;
        run_frame(DATA_W'($urandom), 1'b0, 1'b0, 1'b1);
        run_frame(DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        check_val("b2b_busy_cycles", 32'(busy_cnt), 32'(2 * N * CPB));
        idle_cycles(3, 1'b1);

        // Reset during data bit 3
        i_data  = 6'h2A;
        i_start = 1'b1;
        step();
        i_start  = 1'b0;
        m_sticky = 1'b0;
        for (int j = 0; j < 4 * CPB; j++) step();
        check_val("mid_pre_tx", 32'(o_tx), 32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_val("mid_tx",     32'(o_tx),         32'd1);
        check_val("mid_busy",   32'(o_busy),       32'd0);
        check_val("mid_done",   32'(o_done),       32'd0);
        check_val("mid_sticky", 32'(o_ovf_sticky), 32'd0);
        done_seen = 0;
        for (int j = 0; j < N * CPB; j++) begin
            step();
            if (o_done) done_seen++;
        end
        check_val("mid_no_done", 32'(done_seen), 32'd0);

`ifdef SERIALIZADOR_PARITY_EN
        // Parity: data 0x07 with flag set gives even parity bit 0
        run_frame(6'h07, 1'b1, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);
`endif

        // Randomized frames with random gaps and overflow activity
        for (int k = 0; k < 8; k++) begin
            idle_cycles($urandom_range(0, 3), 1'b1);
            run_frame(DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        idle_cycles(2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
